// File: rtl/seg_scan_display_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment display.
//   - character codes CH_0..CH_9, CH_A..CH_Z, CH_BLANK
//   - SEG_LUT: code -> active-low segment pattern {g,f,e,d,c,b,a}
//   - scan_state_e: per-slot request/capture FSM states
package seg_pkg;

   localparam logic [5:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3,  CH_4 = 6'd4;
   localparam logic [5:0] CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7,  CH_8 = 6'd8,  CH_9 = 6'd9;
   localparam logic [5:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13, CH_E = 6'd14;
   localparam logic [5:0] CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17, CH_I = 6'd18, CH_J = 6'd19;
   localparam logic [5:0] CH_K = 6'd20, CH_L = 6'd21, CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24;
   localparam logic [5:0] CH_P = 6'd25, CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
   localparam logic [5:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33, CH_Y = 6'd34;
   localparam logic [5:0] CH_Z = 6'd35, CH_BLANK = 6'd36;

   // Entry k is the pattern for code k; listed from code 63 down to code 0.
   // Codes 36..63 have no glyph and leave every segment off.
   localparam logic [63:0][6:0] SEG_LUT = {
      {28{7'h7F}},
      7'h24, 7'h11, 7'h09, 7'h55, 7'h63, 7'h41, 7'h07, 7'h12,  // Z Y X W V U T S
      7'h2F, 7'h18, 7'h0C, 7'h40, 7'h2B, 7'h6A, 7'h47, 7'h0A,  // R Q P O N M L K
      7'h61, 7'h79, 7'h09, 7'h42, 7'h0E, 7'h06, 7'h21, 7'h46,  // J I H G F E D C
      7'h03, 7'h08,                                            // B A
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24,  // 9 8 7 6 5 4 3 2
      7'h79, 7'h40                                             // 1 0
   };

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } scan_state_e;

endpackage

// File: rtl/seg_scan_display_if.sv
// Per-digit message interface plus display pins.
//   master (display side): drives ref_sign/refresh/an/seg/dp, reads message/blank
//   slave  (producer/board side): drives message/blank, reads the rest
interface seg_scan_display_if;
   logic [5:0] message;   // character code from the active producer
   logic       blank;     // 1 = all anodes off
   logic       ref_sign;  // one-cycle request strobe at slot start
   logic [1:0] refresh;   // digit index requested/displayed, 0 = rightmost
   logic [3:0] an;        // anodes, active-low
   logic [6:0] seg;       // {g,f,e,d,c,b,a}, active-low
   logic       dp;        // decimal point, active-low

   modport master (input message, blank, output ref_sign, refresh, an, seg, dp);
   modport slave  (output message, blank, input ref_sign, refresh, an, seg, dp);
endinterface

// File: rtl/seg_scan_display_decode.sv
// seg_decode: combinational character code -> segment pattern lookup.
//   code_i  6-bit character code
//   seg_o   active-low segments {g,f,e,d,c,b,a}
module seg_decode
   import seg_pkg::*;
(
   input  logic [5:0] code_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[code_i];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: 4-digit multiplexed 7-segment driver that pulls one
// character per slot from a producer with 2-cycle registered latency.
//   clk, rst_n  clock, asynchronous active-low reset
//   disp_if     message/blank in; ref_sign/refresh/an/seg/dp out
// All outputs are registered from the slot state, so they trail cnt_q by one
// cycle: ref_sign is seen while cnt_q==1, which puts the producer's +2 output
// in place by the capture edge at cnt_q==CAPTURE_DELAY.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int SLOT_CYCLES   = 50000,
   parameter int CAPTURE_DELAY = 3,
   parameter int GUARD_CYCLES  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_display_if.master disp_if
);

   localparam int               CNT_W      = $clog2(SLOT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRECAP = CNT_W'(CAPTURE_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD  = CNT_W'(GUARD_CYCLES);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [5:0]       dbuf_q [4];
   logic             cap_en;
   logic [6:0]       dec_seg;
   logic [3:0]       an_d;

   logic             ref_sign_q;
   logic [1:0]       refresh_q;
   logic [3:0]       an_q;
   logic [6:0]       seg_q;

   seg_decode u_dec (
      .code_i (dbuf_q[idx_q]),
      .seg_o  (dec_seg)
   );

   always_comb begin
      state_d = state_q;
      cap_en  = 1'b0;
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      idx_d   = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
      case (state_q)
         ST_REQ:     state_d = ST_WAIT;
         ST_WAIT:    if (cnt_q == CNT_PRECAP) state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            cap_en  = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD:    if (cnt_q == CNT_LAST) state_d = ST_REQ;
         default:    state_d = ST_REQ;
      endcase
      // Anodes stay dark for the first GUARD_CYCLES of a slot so the new
      // digit's anode never lights with the previous digit's segments.
      an_d = (disp_if.blank || (cnt_q < CNT_GUARD)) ? 4'hF : ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_REQ;
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         for (int i = 0; i < 4; i++) dbuf_q[i] <= CH_BLANK;
         ref_sign_q <= 1'b0;
         refresh_q  <= 2'd0;
         an_q       <= 4'hF;
         seg_q      <= 7'h7F;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         if (cap_en) dbuf_q[idx_q] <= disp_if.message;
         ref_sign_q <= (state_q == ST_REQ);
         refresh_q  <= idx_q;
         an_q       <= an_d;
         // Buffer keeps last frame's code until capture, so unchanged text
         // does not flicker.
         seg_q      <= dec_seg;
      end
   end

   assign disp_if.ref_sign = ref_sign_q;
   assign disp_if.refresh  = refresh_q;
   assign disp_if.an       = an_q;
   assign disp_if.seg      = seg_q;
   assign disp_if.dp       = 1'b1;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

   localparam int SLOT  = 8;
   localparam int FRAME = 4 * SLOT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_display_if ifc ();

   seg_scan_display #(.SLOT_CYCLES(8), .CAPTURE_DELAY(3), .GUARD_CYCLES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .disp_if (ifc)
   );

   // Stimulus: either a producer model (2-cycle latency) or a directly driven code.
   logic       prod_en = 1'b0;
   logic       blank_r = 1'b0;
   logic [5:0] drv = 6'd63;
   logic [5:0] p1, p2;
   logic [5:0] text [4];

   assign ifc.message = prod_en ? p2 : drv;
   assign ifc.blank   = blank_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 6'd63;
         p2 <= 6'd63;
      end else begin
         if (ifc.ref_sign) p1 <= text[ifc.refresh];
         p2 <= p1;
      end
   end

   int checks = 0;
   int errors = 0;
   int n;
   logic [5:0] mbuf [4];

   localparam logic [6:0] LOSE_SEG [4] = '{7'b0000110, 7'b0010010, 7'b1000000, 7'b1000111};
   localparam logic [3:0] LOSE_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   function automatic logic [6:0] ref_seg(input logic [5:0] code);
      case (code)
         6'd0:  return 7'h40;  6'd1:  return 7'h79;  6'd2:  return 7'h24;  6'd3:  return 7'h30;
         6'd4:  return 7'h19;  6'd5:  return 7'h12;  6'd6:  return 7'h02;  6'd7:  return 7'h78;
         6'd8:  return 7'h00;  6'd9:  return 7'h10;  6'd10: return 7'h08;  6'd11: return 7'h03;
         6'd12: return 7'h46;  6'd13: return 7'h21;  6'd14: return 7'h06;  6'd15: return 7'h0E;
         6'd16: return 7'h42;  6'd17: return 7'h09;  6'd18: return 7'h79;  6'd19: return 7'h61;
         6'd20: return 7'h0A;  6'd21: return 7'h47;  6'd22: return 7'h6A;  6'd23: return 7'h2B;
         6'd24: return 7'h40;  6'd25: return 7'h0C;  6'd26: return 7'h18;  6'd27: return 7'h2F;
         6'd28: return 7'h12;  6'd29: return 7'h07;  6'd30: return 7'h41;  6'd31: return 7'h63;
         6'd32: return 7'h55;  6'd33: return 7'h09;  6'd34: return 7'h11;  6'd35: return 7'h24;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"},  32'(ifc.an),       32'hF);
      chk({tag, "_seg"}, 32'(ifc.seg),      32'h7F);
      chk({tag, "_rs"},  32'(ifc.ref_sign), 32'h0);
      chk({tag, "_ref"}, 32'(ifc.refresh),  32'h0);
      chk({tag, "_dp"},  32'(ifc.dp),       32'h1);
   endtask

   // One clock: model predicts outputs for the coming edge from the slot/cycle
   // number since reset, then updates its digit buffer if this is the capture edge.
   task automatic tick(output int c, output int d);
      logic [6:0] es;
      logic [3:0] ea;
      c  = n % SLOT;
      d  = (n / SLOT) % 4;
      es = ref_seg(mbuf[d]);
      ea = (blank_r || c < 2) ? 4'hF : ~(4'b0001 << d);
      if (c == 3) mbuf[d] = prod_en ? text[d] : drv;
      @(posedge clk);
      #1;
      chk("ref_sign", 32'(ifc.ref_sign), 32'(c == 0));
      chk("refresh",  32'(ifc.refresh),  32'(d));
      chk("an",       32'(ifc.an),       32'(ea));
      chk("seg",      32'(ifc.seg),      32'(es));
      chk("dp",       32'(ifc.dp),       32'h1);
      n++;
      @(negedge clk);
   endtask

   // mode: 0 producer, 1 code 8 only at digit 2's capture window, 2 random codes.
   // xchk: 0 none, 1 LOSE constants, 2 capture-window constants, 3 out-of-range.
   task automatic run_frames(input int frames, input int mode, input int xchk, input int skip);
      int c, d, uc, ud;
      for (int f = 0; f < frames; f++) begin
         for (int k = 0; k < FRAME; k++) begin
            uc = n % SLOT;
            ud = (n / SLOT) % 4;
            prod_en = (mode == 0);
            if (mode == 1) drv = (uc == 3 && ud == 2) ? 6'd8 : 6'd63;
            if (mode == 2) begin
               drv = 6'($urandom_range(0, 63));
               if (uc == 0) blank_r = ($urandom_range(0, 3) == 0);
            end
            tick(c, d);
            if (f >= skip && c >= 3) begin
               if (xchk == 1) begin
                  chk("lose_seg", 32'(ifc.seg), 32'(LOSE_SEG[d]));
                  chk("lose_an",  32'(ifc.an),  32'(LOSE_AN[d]));
               end
               if (xchk == 2 && c >= 4)
                  chk("cap_seg", 32'(ifc.seg), (d == 2) ? 32'h00 : 32'h7F);
               if (xchk == 3) begin
                  chk("oor_seg", 32'(ifc.seg), 32'h7F);
                  chk("oor_an_on", 32'(ifc.an != 4'hF), 32'h1);
               end
            end
         end
      end
   endtask

   initial begin
      int c, d;
      n = 0;
      for (int i = 0; i < 4; i++) mbuf[i] = 6'd36;
      text = '{6'd14, 6'd28, 6'd24, 6'd21};   // E S O L -> reads LOSE left to right

      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;

      run_frames(3, 0, 1, 1);                 // LOSE after one warm-up frame
      run_frames(2, 1, 2, 1);                 // capture window only
      blank_r = 1'b1;
      run_frames(1, 0, 0, 0);                 // blanked frame, scan continues
      blank_r = 1'b0;
      run_frames(1, 0, 1, 0);                 // text back immediately
      text = '{6'd36, 6'd63, 6'd36, 6'd63};
      run_frames(2, 0, 3, 1);
      run_frames(6, 2, 0, 0);

      // Mid-slot reset: slot 2, cycle 5.
      blank_r = 1'b0;
      for (int i = 0; i < 4; i++) text[i] = 6'($urandom_range(0, 35));
      for (int k = 0; k < 2 * SLOT + 6; k++) begin
         prod_en = 1'b1;
         tick(c, d);
      end
      rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      @(posedge clk);
      #1;
      chk_reset("held_rst");
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) mbuf[i] = 6'd36;
      run_frames(2, 0, 0, 0);
      run_frames(2, 2, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
